alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational 8-bit ALU (4-bit control, 8-bit operands, 8-bit result, 8-bit flags) between two independent requesters. Each requester issues an operation over a valid/ready handshake and receives its result and flags over a valid/ready response channel. The arbiter grants round-robin, registers operands into the ALU, captures outputs one cycle later, and holds the response until it is accepted. It sits between the datapath's instruction sources and the shared ALU instance.

## Interface
- DW, 8, operand/result/flags width
- CW, 4, ALU control width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- r0_valid, r1_valid  in  1  request present on port 0 / port 1
- r0_ready, r1_ready  out  1  request accepted this cycle
- r0_ctl, r1_ctl  in  CW  ALU control code
- r0_a, r0_b, r1_a, r1_b  in  DW  operands
- s0_valid, s1_valid  out  1  response present for port 0 / port 1
- s0_ready, s1_ready  in  1  response consumed
- s_z  out  DW  result, shared by both response ports
- s_flags  out  DW  flags, shared by both response ports
- alu_ctl  out  CW  registered control to the ALU
- alu_a, alu_b  out  DW  registered operands to the ALU
- alu_z, alu_flags  in  DW  ALU outputs, combinational from alu_*
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If exactly one rN_valid is high, grant that port.
  - If both are high, grant the port not equal to `last`, the one-bit pointer to the last served port.
  - rN_ready is combinational: high only for the granted port, only in IDLE, and only while that port's valid is high.
  - On the handshake edge, latch ctl, a and b into alu_ctl, alu_a and alu_b, record `owner`, and go to EXEC.
- **EXEC** (exactly one cycle)
  - The ALU evaluates the registered inputs.
  - At the end of the cycle, capture alu_z into s_z and alu_flags into s_flags, then go to RESP.
- **RESP**
  - s{owner}_valid is high. The other sN_valid is low.
  - Hold s_z and s_flags stable until s{owner}_ready is high.
  - On that edge, set `last` to `owner` and go to IDLE.
  - No new request is accepted in RESP, even if the opposite port is valid.
- alu_ctl, alu_a and alu_b keep their last values after EXEC. They change only on a new accept.
- Flags are opaque: passed through unmodified, with no interpretation.
- A requester must hold rN_ctl, rN_a and rN_b stable while rN_valid is high and rN_ready is low.
- A requester may drop rN_valid without a handshake. The arbiter then re-arbitrates on the next IDLE cycle.

## Timing
- Accept at edge T. EXEC during cycle T+1. s_valid is high from cycle T+2.
- Minimum occupancy is 3 cycles per operation (accept, exec, response with ready already high). Next accept is possible at edge T+3 at the earliest.
- Reset values:
  - State IDLE, `last` = 1, so port 0 wins the first contention.
  - `owner` = 0.
  - alu_ctl, alu_a, alu_b, s_z, s_flags = 0.
  - All ready and valid outputs = 0. busy = 0.
- Reset asserted mid-operation (EXEC or RESP):
  - All state clears immediately and asynchronously.
  - Any pending response is discarded and never presented.
  - The requester must reissue.
- Deassertion of reset is synchronised externally. The first accept can occur on the first rising edge after release.
- Simultaneous rN_valid and s{owner}_ready: the response completes first and the request waits in IDLE for the next cycle. There is no same-cycle re-accept.

## Test plan
- **Single request:** r0_valid with ctl=4'h0, a=8'h05, b=8'h03. The bench ALU stub returns Z=A+B and FLAGS={7'b0,carry}, and s0_ready is held high.
  - Required: r0_ready pulses at T, alu_a=8'h05 at T+1, s0_valid at T+2 with s_z=8'h08 and s_flags=8'h00, s1_valid stays low.
- **Contention after reset:** r0 (a=8'hFF, b=8'h01) and r1 (a=8'h10, b=8'h20) are both valid.
  - Required: port 0 is served first with s_z=8'h00 and s_flags=8'h01, then port 1 with s_z=8'h30.
  - On a repeated collision, port 1 wins, proving the round-robin.
- **Response backpressure:** s0_ready is held low for 5 cycles.
  - Required: s0_valid, s_z and s_flags are stable for all 5 cycles, r1_ready stays low throughout, and r1 is accepted on the IDLE cycle after s0_ready rises.
- **Request withdrawal:** r1_valid rises, then drops in the same cycle r0_valid rises.
  - Required: r0 is granted and r1_ready is never asserted.
- **Reset mid-RESP:** reset is driven low while s1_valid is high.
  - Required: s1_valid, s_z, s_flags and alu_* read 0 asynchronously.
  - After release, a contention case grants port 0.
- **Back-to-back throughput:** r0_valid and s0_ready are held high continuously.
  - Required: accepts occur every 3 cycles, and busy is low exactly one cycle per operation.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered into the ALU, results captured one cycle later and held until accepted.
module alu_arbiter #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          r0_valid_i,
  output logic          r0_ready_o,
  input  logic [CW-1:0] r0_ctl_i,
  input  logic [DW-1:0] r0_a_i,
  input  logic [DW-1:0] r0_b_i,
  input  logic          r1_valid_i,
  output logic          r1_ready_o,
  input  logic [CW-1:0] r1_ctl_i,
  input  logic [DW-1:0] r1_a_i,
  input  logic [DW-1:0] r1_b_i,
  output logic          s0_valid_o,
  input  logic          s0_ready_i,
  output logic          s1_valid_o,
  input  logic          s1_ready_i,
  output logic [DW-1:0] s_z_o,
  output logic [DW-1:0] s_flags_o,
  output logic [CW-1:0] alu_ctl_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  input  logic [DW-1:0] alu_z_i,
  input  logic [DW-1:0] alu_flags_i,
  output logic          busy_o
);

  // state | meaning
  // IDLE  | waiting for a request, arbitration active
  // EXEC  | ALU evaluating registered operands
  // RESP  | result presented to owner, waiting for its ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] alu_ctl_q, alu_ctl_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [DW-1:0] s_z_q, s_z_d;
  logic [DW-1:0] s_flags_q, s_flags_d;
  logic          grant;
  logic          resp_taken;

  // On contention the port that was not served last wins.
  assign grant      = (r0_valid_i && r1_valid_i) ? ~last_q : r1_valid_i;
  assign resp_taken = owner_q ? s1_ready_i : s0_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      alu_ctl_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      s_z_q     <= '0;
      s_flags_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      alu_ctl_q <= alu_ctl_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      s_z_q     <= s_z_d;
      s_flags_q <= s_flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    alu_ctl_d  = alu_ctl_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    s_z_d      = s_z_q;
    s_flags_d  = s_flags_q;
    r0_ready_o = 1'b0;
    r1_ready_o = 1'b0;
    s0_valid_o = 1'b0;
    s1_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (r0_valid_i || r1_valid_i) begin
          r0_ready_o = ~grant & r0_valid_i;
          r1_ready_o = grant & r1_valid_i;
          owner_d    = grant;
          alu_ctl_d  = grant ? r1_ctl_i : r0_ctl_i;
          alu_a_d    = grant ? r1_a_i : r0_a_i;
          alu_b_d    = grant ? r1_b_i : r0_b_i;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        s_z_d     = alu_z_i;
        s_flags_d = alu_flags_i;
        state_d   = RESP;
      end
      RESP: begin
        s0_valid_o = ~owner_q;
        s1_valid_o = owner_q;
        // Returning to IDLE only; a waiting request is arbitrated next cycle.
        if (resp_taken) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_z_o     = s_z_q;
  assign s_flags_o = s_flags_q;
  assign alu_ctl_o = alu_ctl_q;
  assign alu_a_o   = alu_a_q;
  assign alu_b_o   = alu_b_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_valid = 1'b0, r1_valid = 1'b0;
  logic [CW-1:0] r0_ctl = '0, r1_ctl = '0;
  logic [DW-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic          s0_ready = 1'b0, s1_ready = 1'b0;
  logic          r0_ready, r1_ready, s0_valid, s1_valid, busy;
  logic [DW-1:0] s_z, s_flags, alu_a, alu_b, alu_z, alu_flags;
  logic [CW-1:0] alu_ctl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_ctl_i(r0_ctl),
    .r0_a_i(r0_a), .r0_b_i(r0_b),
    .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_ctl_i(r1_ctl),
    .r1_a_i(r1_a), .r1_b_i(r1_b),
    .s0_valid_o(s0_valid), .s0_ready_i(s0_ready),
    .s1_valid_o(s1_valid), .s1_ready_i(s1_ready),
    .s_z_o(s_z), .s_flags_o(s_flags),
    .alu_ctl_o(alu_ctl), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_z_i(alu_z), .alu_flags_i(alu_flags), .busy_o(busy)
  );

  // ALU stub: {z, flags}; op 0 is add with carry in flags bit 0.
  function automatic logic [2*DW-1:0] alu_ref(input logic [CW-1:0] c,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (c[1:0])
      2'd0:    return {s[DW-1:0], 7'b0, s[DW]};
      2'd1:    return {a - b, 7'b0, (a < b)};
      2'd2:    return {a & b, c, a[3:0]};
      default: return {a ^ b, ~a};
    endcase
  endfunction

  assign {alu_z, alu_flags} = alu_ref(alu_ctl, alu_a, alu_b);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one operation in flight, age counts cycles since accept.
  logic          m_busy = 1'b0, m_port = 1'b0, m_last = 1'b1;
  int            m_age = 0;
  logic [CW-1:0] m_ctl = '0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_z = '0, m_f = '0;
  logic          ev_acc = 1'b0, ev_port = 1'b0, ev_done = 1'b0;

  always @(negedge clk) begin
    logic g, e0, e1, sv0, sv1;
    if (!rst_n) begin
      ev_acc  <= 1'b0;
      ev_done <= 1'b0;
    end else begin
      g   = (r0_valid && r1_valid) ? ~m_last : r1_valid;
      e0  = !m_busy && r0_valid && !g;
      e1  = !m_busy && r1_valid && g;
      sv0 = m_busy && (m_age >= 2) && !m_port;
      sv1 = m_busy && (m_age >= 2) && m_port;
      chk("m_r0_ready", 32'(r0_ready), 32'(e0));
      chk("m_r1_ready", 32'(r1_ready), 32'(e1));
      chk("m_s0_valid", 32'(s0_valid), 32'(sv0));
      chk("m_s1_valid", 32'(s1_valid), 32'(sv1));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_alu_ctl", 32'(alu_ctl), 32'(m_ctl));
      chk("m_alu_a", 32'(alu_a), 32'(m_a));
      chk("m_alu_b", 32'(alu_b), 32'(m_b));
      if (sv0 || sv1) begin
        chk("m_s_z", 32'(s_z), 32'(m_z));
        chk("m_s_flags", 32'(s_flags), 32'(m_f));
      end
      ev_acc  <= e0 || e1;
      ev_port <= e1;
      ev_done <= (sv0 && s0_ready) || (sv1 && s1_ready);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_port <= 1'b0; m_last <= 1'b1; m_age <= 0;
      m_ctl <= '0; m_a <= '0; m_b <= '0; m_z <= '0; m_f <= '0;
    end else if (ev_done) begin
      m_busy <= 1'b0;
      m_last <= m_port;
    end else if (ev_acc) begin
      m_busy <= 1'b1;
      m_age  <= 1;
      m_port <= ev_port;
      m_ctl  <= ev_port ? r1_ctl : r0_ctl;
      m_a    <= ev_port ? r1_a : r0_a;
      m_b    <= ev_port ? r1_b : r0_b;
      {m_z, m_f} <= ev_port ? alu_ref(r1_ctl, r1_a, r1_b) : alu_ref(r0_ctl, r0_a, r0_b);
    end else if (m_busy) begin
      m_age <= m_age + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int n;
    r0_valid = 1'b0; r1_valid = 1'b0; s0_ready = 1'b1; s1_ready = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      tick;
      n++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc0, acc1;
    int last_acc, nacc, nlow;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s0_valid", 32'(s0_valid), 32'd0);
    chk("rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_s_z", 32'(s_z), 32'd0);
    tick; tick;
    rst_n = 1'b1;

    // Single request: 5 + 3
    r0_valid = 1'b1; r0_ctl = 4'h0; r0_a = 8'h05; r0_b = 8'h03; s0_ready = 1'b1;
    @(negedge clk); chk("single_r0_ready", 32'(r0_ready), 32'd1);
    tick; r0_valid = 1'b0;
    @(negedge clk);
    chk("single_alu_a", 32'(alu_a), 32'h05);
    chk("single_exec_s0v", 32'(s0_valid), 32'd0);
    tick;
    @(negedge clk);
    chk("single_s0_valid", 32'(s0_valid), 32'd1);
    chk("single_s_z", 32'(s_z), 32'h08);
    chk("single_s_flags", 32'(s_flags), 32'h00);
    chk("single_s1_valid", 32'(s1_valid), 32'd0);
    tick;
    @(negedge clk); chk("single_done_busy", 32'(busy), 32'd0);

    // Contention after reset
    rst_n = 1'b0; tick; tick; rst_n = 1'b1;
    r0_valid = 1'b1; r0_ctl = 4'h0; r0_a = 8'hFF; r0_b = 8'h01;
    r1_valid = 1'b1; r1_ctl = 4'h0; r1_a = 8'h10; r1_b = 8'h20;
    s0_ready = 1'b1; s1_ready = 1'b1;
    @(negedge clk);
    chk("cont1_r0_ready", 32'(r0_ready), 32'd1);
    chk("cont1_r1_ready", 32'(r1_ready), 32'd0);
    tick; tick;
    @(negedge clk);
    chk("cont1_s0_valid", 32'(s0_valid), 32'd1);
    chk("cont1_s_z", 32'(s_z), 32'h00);
    chk("cont1_s_flags", 32'(s_flags), 32'h01);
    tick;
    @(negedge clk);
    chk("cont2_r1_ready", 32'(r1_ready), 32'd1);
    chk("cont2_r0_ready", 32'(r0_ready), 32'd0);
    tick; tick;
    @(negedge clk);
    chk("cont2_s1_valid", 32'(s1_valid), 32'd1);
    chk("cont2_s_z", 32'(s_z), 32'h30);
    tick;
    @(negedge clk); chk("cont3_r0_ready", 32'(r0_ready), 32'd1);
    tick; r0_valid = 1'b0; r1_valid = 1'b0;
    tick; tick;

    // Response backpressure
    r0_valid = 1'b1; r0_ctl = 4'h0; r0_a = 8'h80; r0_b = 8'h80; s0_ready = 1'b0;
    @(negedge clk); chk("bp_r0_ready", 32'(r0_ready), 32'd1);
    tick;
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_ctl = 4'h1; r1_a = 8'h09; r1_b = 8'h04;
    @(negedge clk); chk("bp_exec_r1_ready", 32'(r1_ready), 32'd0);
    tick;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s0_valid", 32'(s0_valid), 32'd1);
      chk("bp_s_z", 32'(s_z), 32'h00);
      chk("bp_s_flags", 32'(s_flags), 32'h01);
      chk("bp_r1_ready", 32'(r1_ready), 32'd0);
      tick;
    end
    s0_ready = 1'b1;
    @(negedge clk); chk("bp_release_r1_ready", 32'(r1_ready), 32'd0);
    tick;
    @(negedge clk); chk("bp_r1_accept", 32'(r1_ready), 32'd1);
    tick; r1_valid = 1'b0;
    tick;
    @(negedge clk); chk("bp_r1_s_z", 32'(s_z), 32'h05);
    tick;

    // Request withdrawal while port 0 owns a pending response
    r0_valid = 1'b1; r0_ctl = 4'h2; r0_a = 8'hF0; r0_b = 8'h3C; s0_ready = 1'b0;
    @(negedge clk); chk("wd_r0_ready", 32'(r0_ready), 32'd1);
    tick; r0_valid = 1'b0;
    tick; r1_valid = 1'b1; r1_ctl = 4'h3; r1_a = 8'h11; r1_b = 8'h22;
    @(negedge clk); chk("wd_r1_ready_a", 32'(r1_ready), 32'd0);
    tick;
    @(negedge clk); chk("wd_r1_ready_b", 32'(r1_ready), 32'd0);
    tick;
    r1_valid = 1'b0; r0_valid = 1'b1; r0_ctl = 4'h0; r0_a = 8'h01; r0_b = 8'h01; s0_ready = 1'b1;
    @(negedge clk);
    chk("wd_no_same_cycle", 32'(r0_ready), 32'd0);
    chk("wd_r1_ready_c", 32'(r1_ready), 32'd0);
    tick;
    @(negedge clk);
    chk("wd_r0_grant", 32'(r0_ready), 32'd1);
    chk("wd_r1_ready_d", 32'(r1_ready), 32'd0);
    tick; r0_valid = 1'b0;
    tick; tick;

    // Reset mid-RESP with port 1 owning the response
    r1_valid = 1'b1; r1_ctl = 4'h0; r1_a = 8'h40; r1_b = 8'h02; s1_ready = 1'b0;
    @(negedge clk); chk("rr_r1_ready", 32'(r1_ready), 32'd1);
    tick; r1_valid = 1'b0;
    tick;
    @(negedge clk);
    chk("rr_s1_valid", 32'(s1_valid), 32'd1);
    chk("rr_s_z", 32'(s_z), 32'h42);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_async_s1_valid", 32'(s1_valid), 32'd0);
    chk("rr_async_s_z", 32'(s_z), 32'd0);
    chk("rr_async_s_flags", 32'(s_flags), 32'd0);
    chk("rr_async_alu_a", 32'(alu_a), 32'd0);
    chk("rr_async_alu_b", 32'(alu_b), 32'd0);
    chk("rr_async_alu_ctl", 32'(alu_ctl), 32'd0);
    chk("rr_async_busy", 32'(busy), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    r0_valid = 1'b1; r0_ctl = 4'h1; r0_a = 8'h20; r0_b = 8'h30;
    r1_valid = 1'b1; s0_ready = 1'b1; s1_ready = 1'b1;
    @(negedge clk);
    chk("rr_post_r0_ready", 32'(r0_ready), 32'd1);
    chk("rr_post_r1_ready", 32'(r1_ready), 32'd0);
    tick; r0_valid = 1'b0; r1_valid = 1'b0;
    tick; tick;

    // Back-to-back throughput on port 0
    r0_valid = 1'b1; r0_ctl = 4'h3; r0_a = 8'h5A; r0_b = 8'hA5; s0_ready = 1'b1;
    last_acc = -1; nacc = 0; nlow = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (r0_ready) begin
        if (last_acc >= 0) chk("tp_gap", 32'(c - last_acc), 32'd3);
        last_acc = c;
        nacc++;
      end
      if (!busy) nlow++;
    end
    chk("tp_accepts", 32'(nacc), 32'd5);
    chk("tp_busy_low", 32'(nlow), 32'd5);
    tick;
    drain;

    // Randomized traffic, honouring the operand-hold rule
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc0 = r0_ready;
      acc1 = r1_ready;
      tick;
      if (!r0_valid || acc0) begin
        r0_valid = ($urandom_range(0, 2) != 0);
        r0_ctl = 4'($urandom); r0_a = 8'($urandom); r0_b = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        r0_valid = 1'b0;
      end
      if (!r1_valid || acc1) begin
        r1_valid = ($urandom_range(0, 2) != 0);
        r1_ctl = 4'($urandom); r1_a = 8'($urandom); r1_b = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        r1_valid = 1'b0;
      end
      s0_ready = ($urandom_range(0, 2) != 0);
      s1_ready = ($urandom_range(0, 2) != 0);
    end
    drain;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
